// File: rtl/accumulator.sv
// Integrate-and-dump stage: sums ACC_LEN valid samples with saturation and
// presents each total on a valid/ready output register.
module accumulator #(
  parameter bit SIGNED     = 1'b1,
  parameter int DATA_WIDTH = 17,
  parameter int ACC_LEN    = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  clr_i,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  sat_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
);

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  localparam int XW = ACC_WIDTH - DATA_WIDTH;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] data_ext;
  logic [ACC_WIDTH-1:0] sum_clamped;
  logic [ACC_WIDTH:0]   sum;
  logic [CW-1:0]        count;
  logic                 sat_acc;
  logic                 clamp;
  logic                 ext_bit;
  logic                 dump;

  assign ext_bit = SIGNED ? data_i[DATA_WIDTH-1] : 1'b0;

  generate
    if (XW > 0) begin : g_ext
      assign data_ext = {{XW{ext_bit}}, data_i};
    end else begin : g_noext
      assign data_ext = data_i;
    end
  endgenerate

  // One guard bit: signed overflow shows as the top two bits disagreeing,
  // unsigned overflow as a carry out.
  assign sum = {(SIGNED ? acc[ACC_WIDTH-1] : 1'b0), acc}
             + {(SIGNED ? data_ext[ACC_WIDTH-1] : 1'b0), data_ext};

  always_comb begin
    clamp       = 1'b0;
    sum_clamped = sum[ACC_WIDTH-1:0];
    if (SIGNED) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        clamp       = 1'b1;
        sum_clamped = {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
      end
    end else if (sum[ACC_WIDTH]) begin
      clamp       = 1'b1;
      sum_clamped = '1;
    end
  end

  assign dump = valid_i && !clr_i && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      count   <= '0;
      sat_acc <= 1'b0;
    end else if (clr_i || dump) begin
      acc     <= '0;
      count   <= '0;
      sat_acc <= 1'b0;
    end else if (valid_i) begin
      acc     <= sum_clamped;
      count   <= count + CW'(1);
      sat_acc <= sat_acc | clamp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o    <= '0;
      sat_o     <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= dump && valid_o && !ready_i;
      if (dump) begin
        data_o  <= sum_clamped;
        sat_o   <= sat_acc | clamp;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Bench for accumulator: a 20-bit and an 18-bit instance share one stimulus
// stream and are checked against an integer reference model.
module tb_accumulator;

  localparam int DW = 17;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          valid_i, clr_i, ready_i;

  logic [19:0] data_a;
  logic        sat_a, valid_a, ovr_a;
  logic [17:0] data_b;
  logic        sat_b, valid_b, ovr_b;

  int errors = 0;
  int checks = 0;

  accumulator #(.SIGNED(1'b1), .DATA_WIDTH(DW), .ACC_LEN(L), .ACC_WIDTH(20)) dut_a (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .clr_i(clr_i),
    .data_o(data_a), .sat_o(sat_a), .valid_o(valid_a), .ready_i(ready_i), .overrun_o(ovr_a)
  );

  accumulator #(.SIGNED(1'b1), .DATA_WIDTH(DW), .ACC_LEN(L), .ACC_WIDTH(18)) dut_b (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .clr_i(clr_i),
    .data_o(data_b), .sat_o(sat_b), .valid_o(valid_b), .ready_i(ready_i), .overrun_o(ovr_b)
  );

  always #5 clk = ~clk;

  // reference state: index 0 = 20-bit instance, 1 = 18-bit instance
  longint m_acc [2];
  bit     m_sat [2];
  longint m_out [2];
  bit     m_sato[2];
  int     m_cnt;
  bit     m_valid, m_ovr;

  function automatic int aw(input int k);
    return (k == 0) ? 20 : 18;
  endfunction

  function automatic longint sat_clamp(input longint s, input int w, output bit c);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    c = 1'b0;
    if (s > hi) begin c = 1'b1; return hi; end
    if (s < lo) begin c = 1'b1; return lo; end
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_sat[k] = 0; m_out[k] = 0; m_sato[k] = 0;
    end
    m_cnt = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_clock();
    bit     dump, c;
    longint x, s;
    dump = valid_i && !clr_i && (m_cnt == L - 1);
    x = longint'($signed(data_i));
    for (int k = 0; k < 2; k++) begin
      if (clr_i) begin
        m_acc[k] = 0; m_sat[k] = 0;
      end else if (valid_i) begin
        s = sat_clamp(m_acc[k] + x, aw(k), c);
        if (dump) begin
          m_out[k] = s; m_sato[k] = m_sat[k] | c;
          m_acc[k] = 0; m_sat[k] = 0;
        end else begin
          m_acc[k] = s; m_sat[k] = m_sat[k] | c;
        end
      end
    end
    if (clr_i) m_cnt = 0;
    else if (valid_i) m_cnt = dump ? 0 : m_cnt + 1;
    m_ovr = dump && m_valid && !ready_i;
    if (dump) m_valid = 1;
    else if (ready_i) m_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input longint v, input int w);
    return 64'(v & ((longint'(1) << w) - 1));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " valid_a"}, 64'(valid_a), 64'(m_valid));
    chk({tag, " data_a"},  64'(data_a),  mask(m_out[0], 20));
    chk({tag, " sat_a"},   64'(sat_a),   64'(m_sato[0]));
    chk({tag, " ovr_a"},   64'(ovr_a),   64'(m_ovr));
    chk({tag, " valid_b"}, 64'(valid_b), 64'(m_valid));
    chk({tag, " data_b"},  64'(data_b),  mask(m_out[1], 18));
    chk({tag, " sat_b"},   64'(sat_b),   64'(m_sato[1]));
    chk({tag, " ovr_b"},   64'(ovr_b),   64'(m_ovr));
  endtask

  task automatic step(input string tag, input logic [DW-1:0] d, input logic v,
                      input logic c, input logic r);
    data_i = d; valid_i = v; clr_i = c; ready_i = r;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 0; clr_i = 0; ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst = 1'b0;

    // basic dump 1..8
    for (int i = 1; i <= 8; i++) step("basic", DW'(i), 1, 0, 1);
    chk("basic total", 64'(data_a), 64'd36);
    chk("basic valid", 64'(valid_a), 64'd1);
    step("basic idle", '0, 0, 0, 1);
    chk("basic drop", 64'(valid_a), 64'd0);

    // signed samples with idle gaps
    step("gap", DW'(-5), 1, 0, 1);
    for (int i = 0; i < 3; i++) step("gap idle", DW'(i), 0, 0, 1);
    for (int i = 0; i < 7; i++) step("gap", DW'(-5), 1, 0, 1);
    chk("gap total", 64'(data_a), 64'h000FFFD8);

    // saturation in the 18-bit instance only
    for (int i = 0; i < 8; i++) step("sat", DW'(65535), 1, 0, 1);
    chk("sat b total", 64'(data_b), 64'd131071);
    chk("sat b flag", 64'(sat_b), 64'd1);
    chk("sat a total", 64'(data_a), 64'd524280);
    for (int i = 0; i < 8; i++) step("sat next", DW'(1), 1, 0, 1);
    chk("sat next total", 64'(data_b), 64'd8);
    chk("sat next flag", 64'(sat_b), 64'd0);

    // backpressure and overrun
    for (int i = 0; i < 8; i++) step("bp1", DW'(1), 1, 0, 0);
    chk("bp1 total", 64'(data_a), 64'd8);
    for (int i = 0; i < 8; i++) step("bp2", DW'(2), 1, 0, 0);
    chk("bp2 total", 64'(data_a), 64'd16);
    chk("bp2 overrun", 64'(ovr_a), 64'd1);
    step("bp hold", '0, 0, 0, 0);
    chk("bp overrun pulse", 64'(ovr_a), 64'd0);
    chk("bp still valid", 64'(valid_a), 64'd1);
    step("bp release", '0, 0, 0, 1);
    chk("bp released", 64'(valid_a), 64'd0);

    // transfer in the same cycle as a dump
    for (int i = 0; i < 8; i++) step("co1", DW'(3), 1, 0, 0);
    for (int i = 0; i < 7; i++) step("co2", DW'(4), 1, 0, 0);
    step("co2 last", DW'(4), 1, 0, 1);
    chk("co valid", 64'(valid_a), 64'd1);
    chk("co total", 64'(data_a), 64'd32);
    chk("co no overrun", 64'(ovr_a), 64'd0);
    step("co drain", '0, 0, 0, 1);

    // clear with a coincident valid sample
    for (int i = 0; i < 5; i++) step("clr pre", DW'(10), 1, 0, 1);
    step("clr", DW'(10), 1, 1, 1);
    for (int i = 0; i < 8; i++) step("clr post", DW'(1), 1, 0, 1);
    chk("clr total", 64'(data_a), 64'd8);

    // async reset mid-accumulation with a pending result
    for (int i = 0; i < 8; i++) step("rst pend", DW'(7), 1, 0, 0);
    for (int i = 0; i < 3; i++) step("rst part", DW'(9), 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async rst");
    chk("async rst valid", 64'(valid_a), 64'd0);
    #2 rst = 1'b0;
    for (int i = 1; i <= 8; i++) step("post rst", DW'(i * 2), 1, 0, 1);
    chk("post rst total", 64'(data_a), 64'd72);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($signed($urandom_range(0, 200)) - 100);
      step("rand", d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
